booth_pp_reducer: RTL and testbench



---
 rtl/booth_pp_reducer_pkg.sv | 17 +
 rtl/booth_pp_reducer_if.sv | 47 ++++
 rtl/full_adder.sv | 18 +
 rtl/wallace_csa_row.sv | 39 +++
 rtl/booth_pp_reducer.sv | 125 ++++++++++++
 tb/tb_booth_pp_reducer.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/booth_pp_reducer_pkg.sv
// -----------------------------------------------------------------------------
// booth_pp_reducer_pkg
//   Shared constants for the Booth partial-product reducer slice.
//   - PW_DEF     : default product width
//   - PP1_SHIFT  : alignment of partial product 1 (weight 4)
//   - PP2_SHIFT  : alignment of partial product 2 (weight 16)
//   - PW1 / PW2  : widths of partial products 1 and 2 at the default width
// -----------------------------------------------------------------------------
package booth_pp_reducer_pkg;

    localparam int PW_DEF    = 8;
    localparam int PP1_SHIFT = 2;
    localparam int PP2_SHIFT = 4;
    localparam int PW1       = PW_DEF - PP1_SHIFT;
    localparam int PW2       = PW_DEF - PP2_SHIFT;

endpackage

// File: rtl/booth_pp_reducer_if.sv
// -----------------------------------------------------------------------------
// booth_pp_reducer_if
//   Handshake bundle between the Booth partial-product generator, the reducer
//   and the product consumer.
//   Input side : in_valid, in_ready, pp0 (PW), pp1 (PW-2), pp2 (PW-4)
//   Output side: out_valid, out_ready, product (PW)
//   modport master : the environment (drives partial products, accepts product)
//   modport slave  : the reducer
// -----------------------------------------------------------------------------
interface booth_pp_reducer_if
    import booth_pp_reducer_pkg::*;
#(
    parameter int PW = PW_DEF
);

    logic                    in_valid;
    logic                    in_ready;
    logic [PW-1:0]           pp0;
    logic [PW-PP1_SHIFT-1:0] pp1;
    logic [PW-PP2_SHIFT-1:0] pp2;
    logic                    out_valid;
    logic                    out_ready;
    logic [PW-1:0]           product;

    modport master (
        output in_valid,
        output pp0,
        output pp1,
        output pp2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product
    );

    modport slave (
        input  in_valid,
        input  pp0,
        input  pp1,
        input  pp2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product
    );

endinterface

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell used by both the carry-save row and the final
//   ripple adder.
//   Ports: a, b, cin (inputs), s (sum), cout (carry/majority)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/wallace_csa_row.sv
// -----------------------------------------------------------------------------
// wallace_csa_row
//   One Wallace 3:2 carry-save level, PW bits wide, built from full_adder cells.
//   Ports: a, b, c   (PW-bit operands)
//          sum       (bitwise a^b^c)
//          carry     (majority(a,b,c) shifted left by one, truncated to PW)
// -----------------------------------------------------------------------------
module wallace_csa_row
    import booth_pp_reducer_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    input  logic [PW-1:0] c,
    output logic [PW-1:0] sum,
    output logic [PW-1:0] carry
);

    logic [PW-2:0] maj;

    generate
        for (genvar gi = 0; gi < PW - 1; gi++) begin : g_fa
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (c[gi]),
                .s    (sum[gi]),
                .cout (maj[gi])
            );
        end
    endgenerate

    // The top bit's majority would land at weight 2^PW and is discarded,
    // so only its sum is needed.
    assign sum[PW-1] = a[PW-1] ^ b[PW-1] ^ c[PW-1];
    assign carry     = {maj, 1'b0};

endmodule

// File: rtl/booth_pp_reducer.sv
// -----------------------------------------------------------------------------
// booth_pp_reducer
//   Reduces the three sign-extended radix-4 Booth partial products of a 4x4
//   multiply to the PW-bit product:
//     product = (pp0 + pp1*4 + pp2*16) mod 2^PW
//   Stage A registers the carry-save (sum, carry) pair of one Wallace level,
//   stage B registers the carry-propagate result. Both sides use valid/ready;
//   the ready chain is combinational so the pipe sustains one item per cycle.
//   Ports: clk, rst (async, active-high)
//          bus (slave modport): in_valid/in_ready/pp0/pp1/pp2,
//                               out_valid/out_ready/product
// -----------------------------------------------------------------------------
module booth_pp_reducer
    import booth_pp_reducer_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    booth_pp_reducer_if.slave   bus
);

    // Aligned operands
    logic [PW-1:0] op_a;
    logic [PW-1:0] op_b;
    logic [PW-1:0] op_c;

    assign op_a = bus.pp0;
    assign op_b = {bus.pp1, {PP1_SHIFT{1'b0}}};
    assign op_c = {bus.pp2, {PP2_SHIFT{1'b0}}};

    // Carry-save level
    logic [PW-1:0] csa_sum;
    logic [PW-1:0] csa_carry;

    wallace_csa_row #(.PW(PW)) u_csa (
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Pipeline state
    logic          va_reg, va_next;
    logic          vb_reg, vb_next;
    logic [PW-1:0] s_reg, s_next;
    logic [PW-1:0] cy_reg, cy_next;
    logic [PW-1:0] product_reg, product_next;

    // Final carry-propagate adder on the stage A registers
    logic [PW-1:0] ripple_c;
    logic [PW-1:0] add_sum;

    assign ripple_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < PW - 1; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (s_reg[gi]),
                .b    (cy_reg[gi]),
                .cin  (ripple_c[gi]),
                .s    (add_sum[gi]),
                .cout (ripple_c[gi+1])
            );
        end
    endgenerate

    // Carry out of the MSB is dropped: the product is modulo 2^PW.
    assign add_sum[PW-1] = s_reg[PW-1] ^ cy_reg[PW-1] ^ ripple_c[PW-1];

    // Ready chain: each stage can take data if it is empty or is being
    // drained in the same cycle. in_ready never looks at in_valid or pp*.
    logic ready_b;
    logic in_ready;
    logic accept;
    logic load_b;

    assign ready_b  = !vb_reg | bus.out_ready;
    assign in_ready = !va_reg | ready_b;
    assign accept   = bus.in_valid & in_ready;
    assign load_b   = va_reg & ready_b;

    always_comb begin
        va_next      = va_reg;
        vb_next      = vb_reg;
        s_next       = s_reg;
        cy_next      = cy_reg;
        product_next = product_reg;

        if (accept) begin
            s_next  = csa_sum;
            cy_next = csa_carry;
        end
        // A stays full if refilled this cycle, otherwise empties when it
        // hands its word to B.
        va_next = accept | (va_reg & !load_b);

        if (load_b) begin
            product_next = add_sum;
        end
        vb_next = load_b | (vb_reg & !bus.out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va_reg      <= 1'b0;
            vb_reg      <= 1'b0;
            s_reg       <= '0;
            cy_reg      <= '0;
            product_reg <= '0;
        end else begin
            va_reg      <= va_next;
            vb_reg      <= vb_next;
            s_reg       <= s_next;
            cy_reg      <= cy_next;
            product_reg <= product_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vb_reg;
    assign bus.product   = product_reg;

endmodule

// File: tb/tb_booth_pp_reducer.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_reducer
//   Self-checking bench for booth_pp_reducer. The reference is plain integer
//   arithmetic (pp0 + 4*pp1 + 16*pp2) mod 256 kept in an in-order queue of
//   items in flight; in_ready is predicted from the number of items in flight.
// -----------------------------------------------------------------------------
module tb_booth_pp_reducer;

    logic clk;
    logic rst;

    booth_pp_reducer_if #(.PW(8)) bus ();

    booth_pp_reducer #(.PW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] exp_q[$];
    logic       prev_stall   = 1'b0;
    logic [7:0] prev_product = 8'h00;
    logic       last_acc     = 1'b0;
    int         out_count    = 0;

    function automatic logic [7:0] ref_product(int p0, int p1, int p2);
        return 8'((p0 + 4 * p1 + 16 * p2) % 256);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(logic v, logic [7:0] p0, logic [5:0] p1, logic [3:0] p2, logic ordy);
        bus.in_valid  = v;
        bus.pp0       = p0;
        bus.pp1       = p1;
        bus.pp2       = p2;
        bus.out_ready = ordy;
    endtask

    // One clock cycle: check handshake outputs against the model, advance the
    // clock, then update the model with what was exchanged on that edge.
    task automatic cycle();
        logic       acc;
        logic       fire;
        logic       ov;
        logic [7:0] pv;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        fire = bus.out_valid && bus.out_ready;
        ov   = bus.out_valid;
        pv   = bus.product;
        chk("in_ready", 32'(bus.in_ready),
            32'(!(exp_q.size() == 2 && !bus.out_ready)));
        if (prev_stall) begin
            chk("hold_valid", 32'(ov), 32'd1);
            chk("hold_product", 32'(pv), 32'(prev_product));
        end
        if (fire) begin
            chk("output_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("product", 32'(pv), 32'(exp_q[0]));
            end
        end
        @(posedge clk);
        if (fire) begin
            out_count++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back(ref_product(int'(bus.pp0), int'(bus.pp1), int'(bus.pp2)));
        prev_stall   = ov && !bus.out_ready;
        prev_product = pv;
        last_acc     = acc;
        #1;
    endtask

    initial begin
        int base;
        int pushed;
        int cyc;

        // ---------------- reset, no traffic ----------------
        rst = 1'b1;
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_product", 32'(bus.product), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---------------- x=3, y=5 latency ----------------
        drive(1'b1, 8'hFB, 6'h05, 4'h0, 1'b1);
        cycle();
        chk("lat_accept", 32'(last_acc), 32'd1);
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b1);
        chk("lat_not_early", 32'(bus.out_valid), 32'd0);
        cycle();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_product", 32'(bus.product), 32'h0F);
        cycle();
        chk("lat_single", 32'(bus.out_valid), 32'd0);

        // ---------------- wrap ----------------
        drive(1'b1, 8'hFF, 6'h3F, 4'hF, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b1);
        cycle();
        chk("wrap_valid", 32'(bus.out_valid), 32'd1);
        chk("wrap_product", 32'(bus.product), 32'hEB);
        cycle();

        // ---------------- back-to-back ----------------
        drive(1'b1, 8'h01, 6'h00, 4'h0, 1'b1);
        cycle();
        drive(1'b1, 8'h00, 6'h01, 4'h0, 1'b1);
        cycle();
        drive(1'b1, 8'h00, 6'h00, 4'h1, 1'b1);
        chk("b2b_p0", 32'(bus.product), 32'h01);
        cycle();
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b1);
        chk("b2b_p1", 32'(bus.product), 32'h04);
        chk("b2b_v1", 32'(bus.out_valid), 32'd1);
        cycle();
        chk("b2b_p2", 32'(bus.product), 32'h10);
        chk("b2b_v2", 32'(bus.out_valid), 32'd1);
        cycle();
        chk("b2b_drained", 32'(bus.out_valid), 32'd0);

        // ---------------- backpressure ----------------
        base = out_count;
        drive(1'b1, 8'h11, 6'h02, 4'h3, 1'b0);
        cycle();
        drive(1'b1, 8'h20, 6'h07, 4'h1, 1'b0);
        cycle();
        drive(1'b1, 8'h05, 6'h10, 4'h8, 1'b0);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_first", 32'(bus.product), 32'(ref_product(8'h11, 6'h02, 4'h3)));
        cycle();
        chk("bp_no_accept", 32'(last_acc), 32'd0);
        cycle();
        drive(1'b1, 8'h05, 6'h10, 4'h8, 1'b1);
        cycle();
        chk("bp_third_accept", 32'(last_acc), 32'd1);
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b1);
        repeat (4) cycle();
        chk("bp_count", 32'(out_count - base), 32'd3);

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 8'h33, 6'h01, 4'h2, 1'b0);
        cycle();
        drive(1'b1, 8'h44, 6'h03, 4'h5, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b0);
        chk("mid_full", 32'(exp_q.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_product", 32'(bus.product), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        cycle();
        rst = 1'b0;
        base = out_count;
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b1);
        repeat (5) cycle();
        chk("mid_rst_nothing_out", 32'(out_count - base), 32'd0);

        // ---------------- random traffic ----------------
        pushed = 0;
        cyc    = 0;
        while (pushed < 10000 && cyc < 60000) begin
            drive(1'($urandom_range(0, 99) < 70),
                  8'($urandom_range(0, 255)),
                  6'($urandom_range(0, 63)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) < 70));
            cycle();
            if (last_acc) pushed++;
            cyc++;
        end
        chk("random_items_accepted", 32'(pushed >= 10000), 32'd1);
        drive(1'b0, 8'h00, 6'h00, 4'h0, 1'b1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            cycle();
            cyc++;
        end
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_idle", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
